// File: rtl/pipe_add2_pkg.sv
// Shared types and constants for the two-port pipelined adder arbiter.
package pipe_add2_pkg;
  localparam int ADD_LAT = 2;
  localparam int DATA_W  = 8;

  typedef logic port_id_t;

  typedef struct packed {
    logic     val;
    port_id_t id;
  } tag_t;
endpackage

// File: rtl/pipe_add2_datapath.sv
// Two-stage 8-bit adder: low nibble and its carry in stage 1, high nibble in stage 2.
module pipe_add2_datapath
  import pipe_add2_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] in0,
  input  logic [DATA_W-1:0] in1,
  output logic [DATA_W-1:0] out,
  output logic [DATA_W/2-1:0] out_lsn
);
  localparam int HW = DATA_W / 2;

  logic [HW-1:0] lsn_q, a_msn_q, b_msn_q;
  logic          c_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lsn_q   <= '0;
      c_q     <= 1'b0;
      a_msn_q <= '0;
      b_msn_q <= '0;
      out     <= '0;
      out_lsn <= '0;
    end else begin
      {c_q, lsn_q} <= {1'b0, in0[HW-1:0]} + {1'b0, in1[HW-1:0]};
      a_msn_q      <= in0[DATA_W-1:HW];
      b_msn_q      <= in1[DATA_W-1:HW];
      // carry out of the top nibble is dropped: result is mod 2^DATA_W
      out          <= {a_msn_q + b_msn_q + {{(HW-1){1'b0}}, c_q}, lsn_q};
      out_lsn      <= lsn_q;
    end
  end
endmodule

// File: rtl/pipe_add2_resp_buf.sv
// Per-port response FIFO; read and write may coincide at any occupancy, including full.
module pipe_add2_resp_buf
  import pipe_add2_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         wr_en,
  input  logic [DATA_W-1:0]            wr_data,
  output logic                         rd_val,
  input  logic                         rd_rdy,
  output logic [DATA_W-1:0]            rd_data,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DEPTH-1:0][DATA_W-1:0] mem;
  logic [AW-1:0]                wr_ptr, rd_ptr;
  logic                         rd_fire;

  assign rd_val  = (count != '0);
  assign rd_data = mem[rd_ptr];
  assign rd_fire = rd_val & rd_rdy;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (rd_fire) rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CW'(wr_en) - CW'(rd_fire);
    end
  end
endmodule

// File: rtl/pipe_add2_arbiter.sv
// Round-robin sharing of one pipelined adder between two credit-checked ports.
// Define PIPE_ADD2_ARB_STATS_EN to add saturating per-port grant counters.
module pipe_add2_arbiter
  import pipe_add2_pkg::*;
#(
  parameter int BUF_DEPTH = 2
`ifdef PIPE_ADD2_ARB_STATS_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req0_val,
  output logic              req0_rdy,
  input  logic [DATA_W-1:0] req0_in0,
  input  logic [DATA_W-1:0] req0_in1,
  output logic              resp0_val,
  input  logic              resp0_rdy,
  output logic [DATA_W-1:0] resp0_sum,
  input  logic              req1_val,
  output logic              req1_rdy,
  input  logic [DATA_W-1:0] req1_in0,
  input  logic [DATA_W-1:0] req1_in1,
  output logic              resp1_val,
  input  logic              resp1_rdy,
  output logic [DATA_W-1:0] resp1_sum
`ifdef PIPE_ADD2_ARB_STATS_EN
  , output logic [CNT_W-1:0] stat_gnt0
  , output logic [CNT_W-1:0] stat_gnt1
`endif
);
  localparam int CW = $clog2(BUF_DEPTH + 1);
  localparam int IW = $clog2(ADD_LAT + 1);
  localparam int UW = CW + IW + 1;

  logic [1:0]              req_val, req_rdy, resp_val, resp_rdy, resp_fire, fire, elig, wr_en;
  logic [1:0][DATA_W-1:0]  req_a, req_b, resp_sum;
  logic [1:0][CW-1:0]      buf_cnt;
  logic [1:0][IW-1:0]      infl;
  tag_t [ADD_LAT-1:0]      tag_q;
  port_id_t                rr_ptr;
  logic [DATA_W-1:0]       add_a, add_b, add_sum;
  logic [DATA_W/2-1:0]     unused_lsn;

  assign req_val   = {req1_val, req0_val};
  assign req_a     = {req1_in0, req0_in0};
  assign req_b     = {req1_in1, req0_in1};
  assign resp_rdy  = {resp1_rdy, resp0_rdy};
  assign req0_rdy  = req_rdy[0];
  assign req1_rdy  = req_rdy[1];
  assign resp0_val = resp_val[0];
  assign resp1_val = resp_val[1];
  assign resp0_sum = resp_sum[0];
  assign resp1_sum = resp_sum[1];
  assign resp_fire = resp_val & resp_rdy;

  always_comb begin
    infl = '0;
    for (int p = 0; p < 2; p++)
      for (int s = 0; s < ADD_LAT; s++)
        if (tag_q[s].val && tag_q[s].id == port_id_t'(p)) infl[p] = infl[p] + IW'(1);
  end

  for (genvar p = 0; p < 2; p++) begin : g_port
    logic [UW-1:0] used, cap;
    // a result consumed this cycle frees its slot for an issue in the same cycle
    assign used       = UW'(buf_cnt[p]) + UW'(infl[p]);
    assign cap        = UW'(BUF_DEPTH) + UW'(resp_fire[p]);
    assign elig[p]    = (used < cap);
    assign req_rdy[p] = reset_n & elig[p] &
                        (~(req_val[1-p] & elig[1-p]) | (rr_ptr != port_id_t'(p)));
    assign wr_en[p]   = tag_q[ADD_LAT-1].val & (tag_q[ADD_LAT-1].id == port_id_t'(p));

    pipe_add2_resp_buf #(.DEPTH(BUF_DEPTH)) u_buf (
      .clk     (clk),
      .reset_n (reset_n),
      .wr_en   (wr_en[p]),
      .wr_data (add_sum),
      .rd_val  (resp_val[p]),
      .rd_rdy  (resp_rdy[p]),
      .rd_data (resp_sum[p]),
      .count   (buf_cnt[p])
    );
  end

  assign fire  = req_val & req_rdy;
  assign add_a = fire[1] ? req_a[1] : req_a[0];
  assign add_b = fire[1] ? req_b[1] : req_b[0];

  pipe_add2_datapath u_dp (
    .clk     (clk),
    .reset_n (reset_n),
    .in0     (add_a),
    .in1     (add_b),
    .out     (add_sum),
    .out_lsn (unused_lsn)
  );

  // tag pipe mirrors adder latency; rr_ptr at reset favours port 0
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tag_q  <= '0;
      rr_ptr <= 1'b1;
    end else begin
      tag_q[0] <= '{val: |fire, id: fire[1]};
      for (int s = 1; s < ADD_LAT; s++) tag_q[s] <= tag_q[s-1];
      if (|fire) rr_ptr <= fire[1];
    end
  end

`ifdef PIPE_ADD2_ARB_STATS_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stat_gnt0 <= '0;
      stat_gnt1 <= '0;
    end else begin
      if (fire[0] && stat_gnt0 != '1) stat_gnt0 <= stat_gnt0 + CNT_W'(1);
      if (fire[1] && stat_gnt1 != '1) stat_gnt1 <= stat_gnt1 + CNT_W'(1);
    end
  end
`endif
endmodule

// File: tb/tb_pipe_add2_arbiter.sv
// Directed bench for pipe_add2_arbiter: latency, RR order, carry drop, credits, reset.
module tb_pipe_add2_arbiter;
  localparam int BD = 3;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       req0_val, req0_rdy, resp0_val, resp0_rdy;
  logic       req1_val, req1_rdy, resp1_val, resp1_rdy;
  logic [7:0] req0_in0, req0_in1, resp0_sum;
  logic [7:0] req1_in0, req1_in1, resp1_sum;
`ifdef PIPE_ADD2_ARB_STATS_EN
  logic [15:0] stat_gnt0, stat_gnt1;
`endif

  int n_chk = 0, n_pass = 0;
  int fire0 = 0, fire1 = 0, g0 = 0, g1 = 0, n_resp = 0;
  int f0s, f1s, nrs;
  logic [7:0] q0[$], q1[$];

  always #5 clk = ~clk;

  pipe_add2_arbiter #(.BUF_DEPTH(BD)) dut (
    .clk(clk), .reset_n(reset_n),
    .req0_val(req0_val), .req0_rdy(req0_rdy), .req0_in0(req0_in0), .req0_in1(req0_in1),
    .resp0_val(resp0_val), .resp0_rdy(resp0_rdy), .resp0_sum(resp0_sum),
    .req1_val(req1_val), .req1_rdy(req1_rdy), .req1_in0(req1_in0), .req1_in1(req1_in1),
    .resp1_val(resp1_val), .resp1_rdy(resp1_rdy), .resp1_sum(resp1_sum)
`ifdef PIPE_ADD2_ARB_STATS_EN
    , .stat_gnt0(stat_gnt0), .stat_gnt1(stat_gnt1)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    q0.delete(); q1.delete();
    g0 = 0; g1 = 0;
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic send0(input logic [7:0] a, input logic [7:0] b, input logic [7:0] exp, input string tag);
    req0_in0 = a; req0_in1 = b; req0_val = 1'b1;
    #1 chk({tag, "_rdy"}, req0_rdy, 1);
    tick();
    req0_val = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (resp0_val) break;
      tick();
    end
    chk({tag, "_val"}, resp0_val, 1);
    chk({tag, "_sum"}, resp0_sum, exp);
    tick();
  endtask

  // fires and results sampled mid-cycle; result order checked against per-port queues
  always @(negedge clk) begin
    if (reset_n) begin
      if (req0_val && req0_rdy) begin q0.push_back(8'(req0_in0 + req0_in1)); fire0++; g0++; end
      if (req1_val && req1_rdy) begin q1.push_back(8'(req1_in0 + req1_in1)); fire1++; g1++; end
      if (resp0_val && resp0_rdy) begin
        n_resp++;
        if (q0.size() == 0) chk("resp0_unexpected", 1, 0);
        else chk("resp0_order", resp0_sum, q0.pop_front());
      end
      if (resp1_val && resp1_rdy) begin
        n_resp++;
        if (q1.size() == 0) chk("resp1_unexpected", 1, 0);
        else chk("resp1_order", resp1_sum, q1.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0;
    req0_val = 1'b1; req1_val = 1'b1;
    req0_in0 = '0; req0_in1 = '0; req1_in0 = '0; req1_in1 = '0;
    resp0_rdy = 1'b0; resp1_rdy = 1'b0;
    tick(); tick();
    chk("rst_req0_rdy", req0_rdy, 0);
    chk("rst_req1_rdy", req1_rdy, 0);
    chk("rst_resp0_val", resp0_val, 0);
    chk("rst_resp1_val", resp1_val, 0);
    req0_val = 1'b0; req1_val = 1'b0;
    reset_n = 1'b1;
    tick();

    // 0x0F+0x01, fire -> resp_val three cycles later
    req0_in0 = 8'h0F; req0_in1 = 8'h01; req0_val = 1'b1;
    #1 chk("t1_rdy", req0_rdy, 1);
    tick(); req0_val = 1'b0;
    chk("t1_lat1", resp0_val, 0);
    tick(); chk("t1_lat2", resp0_val, 0);
    tick(); chk("t1_lat3", resp0_val, 1);
    chk("t1_sum", resp0_sum, 8'h10);
    resp0_rdy = 1'b1;
    tick(); chk("t1_drained", resp0_val, 0);

    // both ports streaming: port 0 first, then strict alternation
    do_reset();
    resp0_rdy = 1'b1; resp1_rdy = 1'b1;
    req0_in0 = 8'h01; req0_in1 = 8'h02; req1_in0 = 8'h30; req1_in1 = 8'h40;
    req0_val = 1'b1; req1_val = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("t2_gnt0_%0d", k), req0_rdy, (k % 2 == 0));
      chk($sformatf("t2_gnt1_%0d", k), req1_rdy, (k % 2 == 1));
      tick();
    end
    req0_val = 1'b0; req1_val = 1'b0;
    repeat (6) tick();

    send0(8'hFF, 8'h02, 8'h01, "t3_carry");
    send0(8'h88, 8'h88, 8'h10, "t3_wrap");

    // port 0 result path stalled: port 0 limited to BD accepts, port 1 unaffected
    resp0_rdy = 1'b0; resp1_rdy = 1'b1;
    req0_val = 1'b1; req1_val = 1'b1;
    f0s = fire0; f1s = fire1;
    for (int k = 0; k < 12; k++) begin
      req0_in0 = 8'(k); req0_in1 = 8'(8'hF0 + k);
      req1_in0 = 8'(k * 2); req1_in1 = 8'h55;
      if (k == 6) f1s = fire1;
      tick();
    end
    chk("t4_p0_accepts", fire0 - f0s, BD);
    chk("t4_p1_full_rate", fire1 - f1s, 6);
    chk("t4_p0_blocked", req0_rdy, 0);
    chk("t4_p1_rdy", req1_rdy, 1);
    chk("t4_p0_held", resp0_val, 1);

    // full buffer drained by one: credit returns in the same cycle
    req1_val = 1'b0; resp0_rdy = 1'b1; f0s = fire0;
    #1 chk("t5_rdy_same_cycle", req0_rdy, 1);
    tick();
    chk("t5_fired", fire0 - f0s, 1);
    chk("t5_still_val", resp0_val, 1);
    req0_val = 1'b0;
    repeat (10) tick();
    chk("t5_q0_empty", q0.size(), 0);
    chk("t5_q1_empty", q1.size(), 0);
`ifdef PIPE_ADD2_ARB_STATS_EN
    chk("stat_gnt0", stat_gnt0, g0);
    chk("stat_gnt1", stat_gnt1, g1);
`endif

    // reset with two adds in flight: nothing may emerge afterwards
    req0_in0 = 8'h11; req0_in1 = 8'h22; req1_in0 = 8'h33; req1_in1 = 8'h44;
    req0_val = 1'b1; req1_val = 1'b1;
    tick(); tick();
    chk("t6_two_fired", g0 + g1 >= 2, 1);
    reset_n = 1'b0;
    q0.delete(); q1.delete();
    #1;
    chk("t6_resp0_val", resp0_val, 0);
    chk("t6_resp1_val", resp1_val, 0);
    chk("t6_req0_rdy", req0_rdy, 0);
    req0_val = 1'b0; req1_val = 1'b0;
    nrs = n_resp;
    tick(); tick();
    reset_n = 1'b1;
    repeat (6) tick();
    chk("t6_nothing_out", n_resp - nrs, 0);
    chk("t6_resp0_idle", resp0_val, 0);
    chk("t6_resp1_idle", resp1_val, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
